reg_wr_arbiter: RTL and testbench

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

---
 rtl/reg_wr_arbiter_if.sv | 25 ++
 rtl/reg_wr_arbiter.sv | 96 +++++++++
 tb/tb_reg_wr_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wr_arbiter_if.sv
// Bus bundle between write requesters/readers and the arbitrated register bank.
interface reg_wr_arbiter_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
);
    logic              clr;
    logic [2:0]        req;
    logic [3*AW-1:0]   wr_addr;
    logic [3*DW-1:0]   wr_data;
    logic [2:0]        gnt;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic [7:0]        wr_cnt;

    modport master (
        output clr, req, wr_addr, wr_data, rd_addr,
        input  gnt, rd_data, busy, wr_cnt
    );

    modport slave (
        input  clr, req, wr_addr, wr_data, rd_addr,
        output gnt, rd_data, busy, wr_cnt
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Three-requester round-robin write arbiter in front of a 4-entry register bank.
// Each grant is a single GRANT cycle; address/data are taken from the winner during that cycle.
module reg_wr_arbiter #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
) (
    input  logic             clk,
    input  logic             reset,
    reg_wr_arbiter_if.slave  bus
);
    localparam int unsigned NREQ = 3;
    localparam int unsigned NREG = 2**AW;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       sel_q;
    logic [7:0]       wr_cnt_q;
    logic [DW-1:0]    bank_q [NREG];

    logic [1:0]       win_c;
    logic [1:0]       idx_c;
    logic             found_c;
    logic             wr_go_c;
    logic [2:0]       gnt_c;
    logic [AW-1:0]    req_addr_c [NREQ];
    logic [DW-1:0]    req_data_c [NREQ];

    // Round-robin search: ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        win_c   = ptr_q;
        idx_c   = ptr_q;
        found_c = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found_c && bus.req[idx_c]) begin
                win_c   = idx_c;
                found_c = 1'b1;
            end
            idx_c = (idx_c == 2'd2) ? 2'd0 : idx_c + 2'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_addr_c[i] = bus.wr_addr[i*AW +: AW];
            req_data_c[i] = bus.wr_data[i*DW +: DW];
        end
    end

    // A grant only lands if the winner is still requesting and no clear is pending
    assign wr_go_c = (state_q == GRANT) && !bus.clr && bus.req[sel_q];

    always_comb begin
        gnt_c        = '0;
        gnt_c[sel_q] = wr_go_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            sel_q    <= 2'd0;
            wr_cnt_q <= 8'd0;
            for (int r = 0; r < int'(NREG); r++) bank_q[r] <= '0;
        end else if (bus.clr) begin
            state_q  <= IDLE;
            wr_cnt_q <= 8'd0;
            for (int r = 0; r < int'(NREG); r++) bank_q[r] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_c) begin
                        sel_q   <= win_c;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    state_q <= IDLE;
                    if (wr_go_c) begin
                        bank_q[req_addr_c[sel_q]] <= req_data_c[sel_q];
                        ptr_q <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                        if (wr_cnt_q != 8'hFF) wr_cnt_q <= wr_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.busy    = (state_q == GRANT);
    assign bus.rd_data = bank_q[bus.rd_addr];
    assign bus.wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: expected grants queued at drive time, popped when gnt appears.
module tb_reg_wr_arbiter;
    logic clk;
    logic reset;

    reg_wr_arbiter_if #(.DW(8), .AW(2)) bus ();

    reg_wr_arbiter #(.DW(8), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0] g;
        logic [1:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] exp_bank [4];
    int         exp_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 4; a++) exp_bank[a] = 8'h00;
        exp_cnt = 0;
    endtask

    task automatic check_bank(input string tag);
        for (int a = 0; a < 4; a++) begin
            bus.rd_addr = 2'(a);
            #1;
            chk($sformatf("%s_rd%0d", tag, a), 32'(bus.rd_data), 32'(exp_bank[a]));
        end
        chk({tag, "_cnt"}, 32'(bus.wr_cnt), 32'(exp_cnt));
    endtask

    task automatic pulse_reset();
        bus.req = '0;
        bus.clr = 1'b0;
        reset   = 1'b1;
        #3;
        reset   = 1'b0;
        model_clear();
    endtask

    task automatic do_write(input int r, input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.req              = 3'(1 << r);
        bus.wr_addr[r*2 +: 2] = a;
        bus.wr_data[r*8 +: 8] = d;
        sb.push_back('{3'(1 << r), a, d});
        @(posedge clk);
        @(posedge clk); #1;
        bus.req = '0;
    endtask

    // Grant monitor: every observed grant must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && bus.gnt != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexp_gnt", 32'(bus.gnt), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("gnt", 32'(bus.gnt), 32'(e.g));
                exp_bank[e.a] = e.d;
                if (exp_cnt != 255) exp_cnt++;
            end
        end
    end

    initial begin
        logic [2:0] g;
        logic [2:0] drop_prev;
        int         last_cyc;

        reset       = 1'b1;
        bus.clr     = 1'b0;
        bus.req     = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        model_clear();

        // Reset state
        @(negedge clk);
        chk("rst_gnt",  32'(bus.gnt),     32'h0);
        chk("rst_busy", 32'(bus.busy),    32'h0);
        chk("rst_rd",   32'(bus.rd_data), 32'h0);
        chk("rst_cnt",  32'(bus.wr_cnt),  32'h0);
        reset = 1'b0;

        // Single write, including old-value read during GRANT
        @(posedge clk); #1;
        bus.req         = 3'b001;
        bus.wr_addr[1:0] = 2'd2;
        bus.wr_data[7:0] = 8'hA5;
        bus.rd_addr     = 2'd2;
        sb.push_back('{3'b001, 2'd2, 8'hA5});
        @(negedge clk);
        chk("idle_gnt",  32'(bus.gnt),  32'h0);
        chk("idle_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        chk("grant_busy",   32'(bus.busy),    32'h1);
        chk("grant_rd_old", 32'(bus.rd_data), 32'h0);
        @(posedge clk); #1;
        bus.req = '0;
        chk("single_rd", 32'(bus.rd_data), 32'hA5);
        chk("single_cnt", 32'(bus.wr_cnt), 32'h1);
        check_bank("single");

        // Fairness from ptr=0: 001,010,100,001 with 2-cycle spacing
        @(posedge clk); #1;
        pulse_reset();
        bus.wr_addr = {2'd2, 2'd1, 2'd0};
        bus.wr_data = {8'h12, 8'h11, 8'h10};
        sb.push_back('{3'b001, 2'd0, 8'h10});
        sb.push_back('{3'b010, 2'd1, 8'h11});
        sb.push_back('{3'b100, 2'd2, 8'h12});
        sb.push_back('{3'b001, 2'd0, 8'h10});
        bus.req   = 3'b111;
        drop_prev = '0;
        last_cyc  = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g = bus.gnt;
            if (g != 3'b000) begin
                if (last_cyc >= 0) chk("gnt_spacing", 32'(c - last_cyc), 32'd2);
                last_cyc = c;
            end
            @(posedge clk); #1;
            bus.req   = (bus.req | drop_prev) & ~g;
            drop_prev = g;
        end
        bus.req = '0;
        chk("fair_pending", 32'(sb.size()), 32'd0);
        check_bank("fair");

        // Withdrawal: one-cycle req[1] reaches GRANT but grants nothing
        @(posedge clk); #1;
        bus.req = 3'b010;
        @(posedge clk); #1;
        bus.req = '0;
        @(negedge clk);
        chk("wd_busy", 32'(bus.busy), 32'h1);
        chk("wd_gnt",  32'(bus.gnt),  32'h0);
        @(posedge clk); #1;
        check_bank("wd");

        // Pointer untouched by withdrawal: still points at requester 1
        bus.wr_data = {8'h22, 8'h21, 8'h20};
        bus.req     = 3'b111;
        sb.push_back('{3'b010, 2'd1, 8'h21});
        @(posedge clk);
        @(posedge clk); #1;
        bus.req = '0;
        check_bank("ptr");

        // Clear during GRANT aborts the write and wipes the bank/count
        @(posedge clk); #1;
        bus.wr_addr = {2'd3, 2'd1, 2'd0};
        bus.wr_data = {8'h3C, 8'h21, 8'h20};
        bus.req     = 3'b100;
        @(posedge clk); #1;
        bus.clr = 1'b1;
        @(negedge clk);
        chk("clr_gnt",  32'(bus.gnt),  32'h0);
        @(posedge clk); #1;
        bus.clr = 1'b0;
        bus.req = '0;
        model_clear();
        chk("clr_busy", 32'(bus.busy), 32'h0);
        check_bank("clr");

        // Asynchronous reset in the middle of a GRANT
        do_write(1, 2'd3, 8'h5A);
        @(posedge clk); #1;
        check_bank("pre_rst");
        @(posedge clk); #1;
        bus.req          = 3'b001;
        bus.wr_addr[1:0] = 2'd1;
        bus.wr_data[7:0] = 8'h77;
        @(posedge clk); #1;
        chk("pre_rst_gnt", 32'(bus.gnt), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_gnt",  32'(bus.gnt),  32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        bus.req = '0;
        @(negedge clk); #1;
        reset = 1'b0;
        model_clear();
        check_bank("arst");

        // Saturation: 260 completed writes
        for (int n = 0; n < 260; n++)
            do_write(int'($urandom_range(2, 0)), 2'($urandom_range(3, 0)), 8'($urandom));
        @(posedge clk); #1;
        chk("sat_cnt", 32'(bus.wr_cnt), 32'd255);
        check_bank("sat");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
